// File: rtl/instr_cache_refill.sv
// instr_cache_refill: refill engine (write side) of a direct-mapped I-cache.
// 16 blocks x 32 words. On a miss it invalidates the target block, fetches
// every word of the block over a req/ack handshake, writes the words, then
// writes the tag, sets the valid bit and pulses done_o.
// Optional feature macro: ICACHE_REFILL_CWF_EN (critical word first). When
// defined, the fetch starts at the missing word and wraps; otherwise it
// always starts at word 0.
module instr_cache_refill #(
  parameter int TAG_W    = 21,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                miss_i,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]   miss_addr_i,
  input  logic                                flush_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                mem_req_o,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   mem_addr_o,
  input  logic                                mem_ack_i,
  input  logic [31:0]                         mem_data_i,
  output logic                                valid_clr_o,
  output logic                                wr_en_o,
  output logic [INDEX_W-1:0]                  wr_index_o,
  output logic [OFFSET_W-1:0]                 wr_offset_o,
  output logic [31:0]                         wr_data_o,
  output logic                                tag_wr_o,
  output logic [TAG_W-1:0]                    wr_tag_o
);

  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INVAL  = 3'd1;
  localparam logic [2:0] REQ    = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  logic [2:0]          state_q,  state_d;
  logic [TAG_W-1:0]    tag_q,    tag_d;
  logic [INDEX_W-1:0]  index_q,  index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [OFFSET_W-1:0] cnt_q,    cnt_d;
  logic [31:0]         data_q,   data_d;

  // Field split of the incoming word address.
  logic [TAG_W-1:0]    miss_tag;
  logic [INDEX_W-1:0]  miss_index;
  logic [OFFSET_W-1:0] start_offset;

  assign miss_tag   = miss_addr_i[ADDR_W-1 -: TAG_W];
  assign miss_index = miss_addr_i[OFFSET_W +: INDEX_W];

`ifdef ICACHE_REFILL_CWF_EN
  // Critical word first: begin with the word that missed.
  assign start_offset = miss_addr_i[OFFSET_W-1:0];
`else
  // Linear fill from word 0; the miss offset bits are not needed.
  logic unused_miss_offset;
  assign unused_miss_offset = ^miss_addr_i[OFFSET_W-1:0];
  assign start_offset       = '0;
`endif

  // Next-state and datapath-register update; flush overrides everything
  // outside IDLE and discards any ack seen in the same cycle.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) begin
          tag_d    = miss_tag;
          index_d  = miss_index;
          offset_d = start_offset;
          cnt_d    = '0;
          state_d  = INVAL;
        end
      end
      INVAL: begin
        state_d = REQ;
      end
      REQ: begin
        if (mem_ack_i) begin
          data_d  = mem_data_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Offset wraps naturally at the block boundary.
        offset_d = offset_q + OFFSET_W'(1);
        cnt_d    = cnt_q + OFFSET_W'(1);
        state_d  = (cnt_q == '1) ? COMMIT : REQ;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      offset_d = offset_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
    end
  end

  // State and latched fields; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Strobes are decoded straight from the state register.
  assign busy_o      = (state_q != IDLE);
  assign valid_clr_o = (state_q == INVAL);
  assign mem_req_o   = (state_q == REQ);
  assign wr_en_o     = (state_q == WRITE);
  assign tag_wr_o    = (state_q == COMMIT);
  assign done_o      = (state_q == COMMIT);

  // Address and write fields come from latched registers only, so they
  // are stable for the whole handshake.
  assign mem_addr_o  = {tag_q, index_q, offset_q};
  assign wr_index_o  = index_q;
  assign wr_offset_o = offset_q;
  assign wr_data_o   = data_q;
  assign wr_tag_o    = tag_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Scoreboard bench for instr_cache_refill: stimulus pushes expected cache-side
// events (invalidate, word writes, commit); a monitor pops and compares them
// whenever the DUT strobes. A memory responder answers requests with
// address-derived data and a programmable number of wait cycles.
module tb_instr_cache_refill;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        miss_i;
  logic [29:0] miss_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        valid_clr_o;
  logic        wr_en_o;
  logic [3:0]  wr_index_o;
  logic [4:0]  wr_offset_o;
  logic [31:0] wr_data_o;
  logic        tag_wr_o;
  logic [20:0] wr_tag_o;

  always #5 clk_i = ~clk_i;

  instr_cache_refill dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .miss_i      (miss_i),
    .miss_addr_i (miss_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .valid_clr_o (valid_clr_o),
    .wr_en_o     (wr_en_o),
    .wr_index_o  (wr_index_o),
    .wr_offset_o (wr_offset_o),
    .wr_data_o   (wr_data_o),
    .tag_wr_o    (tag_wr_o),
    .wr_tag_o    (wr_tag_o)
  );

  typedef struct {
    int          kind;   // 0 invalidate, 1 word write, 2 commit
    logic [3:0]  idx;
    logic [4:0]  off;
    logic [31:0] data;
    logic [20:0] tag;
    int          cyc;    // commit cycle counted from INVAL = 1
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  fails    = 0;
  int  mem_wait = 0;
  int  wr_seen  = 0;
  int  cyc      = 0;

  function automatic logic [31:0] memdata(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected events for one refill of word address waddr.
  task automatic push_refill(input logic [29:0] waddr, input int nwords,
                             input bit commit, input int cyc_exp);
    ev_t        e;
    logic [4:0] start;
`ifdef ICACHE_REFILL_CWF_EN
    start = waddr[4:0];
`else
    start = 5'd0;
`endif
    e.kind = 0; e.idx = waddr[8:5]; e.off = 5'd0; e.data = 32'd0;
    e.tag = 21'd0; e.cyc = 0;
    exp_q.push_back(e);
    for (int k = 0; k < nwords; k++) begin
      e.kind = 1;
      e.off  = start + 5'(k);
      e.data = memdata({waddr[29:5], e.off});
      exp_q.push_back(e);
    end
    if (commit) begin
      e.kind = 2; e.off = 5'd0; e.data = 32'd0;
      e.tag  = waddr[29:9]; e.cyc = cyc_exp;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one line per transaction observed on the cache write side.
  always @(negedge clk_i) begin
    ev_t e;
    int  kind;
    if (rst_ni) begin
      if (valid_clr_o) cyc = 1;
      else             cyc++;
      if (valid_clr_o || wr_en_o || tag_wr_o || done_o) begin
        kind = valid_clr_o ? 0 : (wr_en_o ? 1 : 2);
        check("one_strobe", 64'(32'(valid_clr_o) + 32'(wr_en_o) + 32'(tag_wr_o)), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got kind %0d idx %0d expected no event", kind, wr_index_o);
        end else begin
          e = exp_q.pop_front();
          $display("t=%0t kind=%0d idx=%0d off=%0d data=%08h tag=%06h cyc=%0d",
                   $time, kind, wr_index_o, wr_offset_o, wr_data_o, wr_tag_o, cyc);
          check("event_kind", 64'(kind), 64'(e.kind));
          check("wr_index", 64'(wr_index_o), 64'(e.idx));
          if (kind == 1) begin
            wr_seen++;
            check("wr_offset", 64'(wr_offset_o), 64'(e.off));
            check("wr_data", 64'(wr_data_o), 64'(e.data));
          end
          if (kind == 2) begin
            check("wr_tag", 64'(wr_tag_o), 64'(e.tag));
            check("done_with_tag_wr", 64'(done_o), 64'(tag_wr_o));
            check("commit_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Memory responder with programmable wait cycles per word.
  logic [29:0] hold_addr;
  int          wcnt = 0;
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o) begin
      if (wcnt == 0) hold_addr = mem_addr_o;
      else           check("mem_addr_stable", 64'(mem_addr_o), 64'(hold_addr));
      if (wcnt < mem_wait) begin
        mem_ack_i = 1'b0;
        wcnt++;
      end else begin
        mem_ack_i  = 1'b1;
        mem_data_i = memdata(mem_addr_o);
        wcnt       = 0;
      end
    end else begin
      mem_ack_i = 1'b0;
      wcnt      = 0;
    end
  end

  task automatic run_miss(input logic [29:0] waddr, input int waits, input int cyc_exp);
    int n = 0;
    mem_wait = waits;
    push_refill(waddr, 32, 1'b1, cyc_exp);
    @(posedge clk_i); #1;
    miss_addr_i = waddr;
    miss_i      = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL refill_timeout: got %0d events pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
    miss_i = 1'b0;
    check("busy_after_done", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int n;
    rst_ni      = 1'b0;
    miss_i      = 1'b0;
    miss_addr_i = 30'd0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_data_i  = 32'd0;
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_valid_clr", 64'(valid_clr_o), 64'd0);
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_tag_wr", 64'(tag_wr_o), 64'd0);
    check("rst_wr_fields", 64'({wr_index_o, wr_offset_o, wr_tag_o}), 64'd0);
    check("rst_wr_data", 64'(wr_data_o), 64'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Miss at byte 0x480: index 9, tag 0, zero wait.
    run_miss(30'h0000_0120, 0, 66);

    // Three wait cycles per word.
    run_miss(30'h0ABC_D123, 3, 66 + 96);

    // Miss and flush together in IDLE: nothing accepted.
    @(posedge clk_i); #1;
    miss_addr_i = 30'h0000_0120;
    miss_i      = 1'b1;
    flush_i     = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      check("idle_miss_flush_busy", 64'(busy_o), 64'd0);
    end
    miss_i  = 1'b0;
    flush_i = 1'b0;

    // Flush during the 10th WRITE cycle.
    mem_wait = 1;
    wr_seen  = 0;
    push_refill(30'h0012_34A7, 10, 1'b0, 0);
    @(posedge clk_i); #1;
    miss_addr_i = 30'h0012_34A7;
    miss_i      = 1'b1;
    n = 0;
    while (wr_seen < 10 && n < 500) begin
      @(negedge clk_i); #1;
      n++;
    end
    check("flush_reached_10_writes", 64'(wr_seen), 64'd10);
    flush_i = 1'b1;
    miss_i  = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_mem_req", 64'(mem_req_o), 64'd0);
    repeat (6) @(posedge clk_i);
    check("flush_pending_events", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // A new miss after the flush is accepted normally.
    run_miss(30'h0012_34A7, 0, 66);

    // Miss at offset 30: order 30,31,0..29 with CWF, else 0..31.
    run_miss({21'h12345, 4'h5, 5'd30}, 0, 66);

    // Asynchronous reset while in REQ, between clock edges.
    mem_wait = 20;
    push_refill(30'h0000_0120, 32, 1'b1, 66);
    @(posedge clk_i); #1;
    miss_addr_i = 30'h0000_0120;
    miss_i      = 1'b1;
    n = 0;
    while (!mem_req_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_req", 64'(mem_req_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    miss_i = 1'b0;
    #1;
    check("async_rst_mem_req", 64'(mem_req_o), 64'd0);
    check("async_rst_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("post_rst_mem_addr", 64'(mem_addr_o), 64'd0);

    // Recovery after reset.
    run_miss(30'h0000_0120, 0, 66);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_cache_refill.md
# instr_cache_refill

Refill engine for the direct-mapped instruction cache: 16 blocks of 32 words, address split tag[31:11] / index[10:7] / offset[6:2]. On a miss it invalidates the target block, fetches all 32 words from main memory over a req/ack handshake, and writes them into the block storage. It then writes the tag, sets the valid bit and signals completion. It is the write side of the cache: the read path only looks up, and this block is the only writer of block data, tags and valid bits.

## Interface
- TAG_W, 21, tag width (address bits 31:11)
- INDEX_W, 4, block index width (bits 10:7)
- OFFSET_W, 5, word offset width (bits 6:2); words per block = 2**OFFSET_W
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- miss_i  in  1  refill request, level, sampled only in IDLE
- miss_addr_i  in  30  word address [31:2] of missing instruction, sampled with miss_i
- flush_i  in  1  abort refill / force IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on successful commit
- mem_req_o  out  1  memory read request
- mem_addr_o  out  30  word address of requested word
- mem_ack_i  in  1  memory data valid, only meaningful while mem_req_o=1
- mem_data_i  in  32  memory read data, valid with mem_ack_i
- valid_clr_o  out  1  clear valid bit of block wr_index_o
- wr_en_o  out  1  write wr_data_o into block wr_index_o, word wr_offset_o
- wr_index_o  out  INDEX_W  target block
- wr_offset_o  out  OFFSET_W  target word
- wr_data_o  out  32  write data
- tag_wr_o  out  1  write wr_tag_o to block wr_index_o and set its valid bit
- wr_tag_o  out  TAG_W  tag to store

## Operation
- States: IDLE, INVAL, REQ, WRITE, COMMIT.
- IDLE: if miss_i=1 and flush_i=0, latch tag, index and start offset from miss_addr_i, clear word counter, go to INVAL.
- INVAL: valid_clr_o=1 for one cycle, go to REQ.
- REQ: mem_req_o=1, mem_addr_o={tag,index,offset}. Address is held stable until ack. On mem_ack_i=1, latch mem_data_i and go to WRITE; otherwise stay.
- WRITE: wr_en_o=1 for one cycle with the latched data and the current offset. Then offset increments modulo 32 (wraps 31→0) and the word counter increments. If the counter was 31, go to COMMIT; else go to REQ.
- COMMIT: tag_wr_o=1 and done_o=1 for one cycle, go to IDLE.
- flush_i=1 in any non-IDLE state: next state is IDLE and outputs drop next cycle. No commit occurs and done_o stays 0. The block stays invalid; partially written words are harmless. An ack arriving in the same cycle as flush is discarded.
- Same cycle miss_i=1 and flush_i=1 in IDLE: flush wins, nothing is accepted.
- miss_i in non-IDLE states is ignored. The requester holds miss_i until it sees done_o, or re-issues it after a flush.
- wr_index_o, wr_tag_o and wr_offset_o are driven from latched registers at all times. Strobes (valid_clr_o, wr_en_o, tag_wr_o, done_o, mem_req_o) are state-decoded and glitch-free.

## Timing
- Reset: state IDLE, all outputs 0, all latched registers 0.
- Accept: miss_i is seen at edge N and INVAL is active in cycle N+1.
- With zero memory wait (ack in the first REQ cycle), each word takes 2 cycles (REQ, WRITE). Total time from accept to done_o is 1 + 64 + 1 = 66 cycles. Each wait cycle adds 1.
- done_o and tag_wr_o assert in the same cycle. busy_o falls the following cycle, and a new miss can be accepted that same cycle (IDLE).
- Reset asserted mid-refill returns to IDLE immediately (asynchronously). The cache valid bit for the target stays cleared.

## Configuration
- ICACHE_REFILL_CWF_EN defined: critical word first. The start offset is miss_addr_i[6:2], and the fetch proceeds upward, wrapping 31→0, until all 32 words are written.
- Not defined: the start offset is always 0, and the fetch order is 0..31 regardless of the miss address.

## Test plan
- Reset then miss at 0x0000_0480, ack every REQ cycle → valid_clr_o for index 9, 32 writes at offsets 0..31 with the memory data. tag_wr_o with tag 0 and done_o come exactly 66 cycles after accept.
- Memory inserts 3 wait cycles on every word → mem_addr_o is stable during each wait, and done_o comes at 66+96 cycles.
- flush_i in the 10th WRITE cycle → no further writes, no tag_wr_o, no done_o, and busy_o=0 the next cycle. A new miss is then accepted normally.
- miss_i and flush_i both high in IDLE → stays IDLE, no valid_clr_o.
- With ICACHE_REFILL_CWF_EN, miss offset 30 → write order 30,31,0,1..29 with matching mem_addr_o. Without the macro, the order is 0..31.
- Async reset (rst_ni low) mid-REQ with no clock edge → mem_req_o and busy_o go to 0 immediately.
